button_conditioner: RTL

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 129 ++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// Five-button conditioner: 2-flop synchronizer, counter debounce, press pulse and
// optional auto-repeat (build with BUTTON_AUTOREPEAT_EN defined to enable repeats).
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 10000000
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic [4:0] btn_in,
    output logic [4:0] btn_level,
    output logic [4:0] btn_press,
    output logic [4:0] btn_repeat
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [4:0]       sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q [5];
    logic [CNT_W-1:0] cnt_d [5];
    logic [4:0]       level_q, level_d;
    logic [4:0]       press_q, repeat_q;
    logic [4:0]       rise, mask;

    always_comb begin
        level_d = level_q;
        for (int i = 0; i < 5; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                level_d[i] = ~level_q[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        rise = level_d & ~level_q;
        // Opposing pairs held together would fight each other; silence both.
        mask = {1'b0, {2{level_d[2] & level_d[3]}}, {2{level_d[0] & level_d[1]}}};
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            press_q <= '0;
            for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= rise;
            for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
        end
    end

`ifdef BUTTON_AUTOREPEAT_EN
    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    localparam logic [25:0] DELAY_LAST = 26'(REPEAT_DELAY - 1);
    localparam logic [25:0] RATE_LAST  = 26'(REPEAT_RATE - 1);

    state_t      state_q [5];
    logic [25:0] timer_q [5];

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            repeat_q <= '0;
            for (int i = 0; i < 5; i++) begin
                state_q[i] <= IDLE;
                timer_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (!level_d[i]) begin
                    state_q[i]  <= IDLE;
                    timer_q[i]  <= '0;
                    repeat_q[i] <= 1'b0;
                end else begin
                    case (state_q[i])
                        IDLE: begin
                            repeat_q[i] <= rise[i] & ~mask[i];
                            timer_q[i]  <= '0;
                            if (rise[i]) state_q[i] <= DELAY;
                        end
                        DELAY: begin
                            if (timer_q[i] == DELAY_LAST) begin
                                state_q[i]  <= REPEAT;
                                timer_q[i]  <= '0;
                                repeat_q[i] <= ~mask[i];
                            end else begin
                                timer_q[i]  <= timer_q[i] + 26'd1;
                                repeat_q[i] <= 1'b0;
                            end
                        end
                        REPEAT: begin
                            if (timer_q[i] == RATE_LAST) begin
                                timer_q[i]  <= '0;
                                repeat_q[i] <= ~mask[i];
                            end else begin
                                timer_q[i]  <= timer_q[i] + 26'd1;
                                repeat_q[i] <= 1'b0;
                            end
                        end
                        default: begin
                            state_q[i]  <= IDLE;
                            timer_q[i]  <= '0;
                            repeat_q[i] <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end
`else
    always_ff @(posedge clk_100MHz) begin
        if (reset) repeat_q <= '0;
        else       repeat_q <= rise & ~mask;
    end
`endif

    assign btn_level  = level_q;
    assign btn_press  = press_q;
    assign btn_repeat = repeat_q;

endmodule
